// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator drain: default widths, FSM state
// type and output saturation limits.
package acc_pkg;

  localparam int ACC_W_DEF = 20;
  localparam int OUT_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Signed saturation bounds for a w-bit two's complement output.
  function automatic int satHi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int satLo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int OUT_MAX_DEF = satHi(OUT_W_DEF);
  localparam int OUT_MIN_DEF = satLo(OUT_W_DEF);

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: round-half-up arithmetic right shift, optional
// ReLU, then signed saturation down to OUT_W bits.
module requant_sat
  import acc_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic        [SHIFT_W-1:0] s,
  input  logic                      relu,
  output logic signed [OUT_W-1:0]   q
);

  localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(satHi(OUT_W));
  localparam logic signed [ACC_W:0] LO = (ACC_W + 1)'(satLo(OUT_W));

  logic        [31:0] sWide;
  logic signed [ACC_W:0] aExt;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  // Shifts wider than the accumulator drop the rounding term, so the result
  // collapses to the sign of the input (0 or -1).
  always_comb begin
    sWide = 32'(s);
    aExt  = {a[ACC_W-1], a};
    rnd   = '0;
    if (sWide != 32'd0 && sWide <= 32'(ACC_W))
      rnd = (ACC_W + 1)'(1) << (sWide - 32'd1);
    sum = aExt + rnd;
    r   = sum >>> sWide;
    if (relu && r[ACC_W])
      r = '0;
    if (r > HI)
      q = HI[OUT_W-1:0];
    else if (r < LO)
      q = LO[OUT_W-1:0];
    else
      q = r[OUT_W-1:0];
  end

endmodule

// File: rtl/acc_drain.sv
// Snapshots a row of PE accumulators and streams the requantised values out
// one per cycle on a valid/ready port, allowing back-to-back tiles.
module acc_drain
  import acc_pkg::*;
#(
  parameter int NUM_PE  = 4,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = 5
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic [NUM_PE*ACC_W-1:0]     iAcc,
  input  logic                        iCapture,
  input  logic [SHIFT_W-1:0]          iShift,
  input  logic                        iRelu,
  output logic                        oValid,
  input  logic                        iReady,
  output logic [OUT_W-1:0]            oData,
  output logic [$clog2(NUM_PE)-1:0]   oIndex,
  output logic                        oLast,
  output logic                        oBusy,
  output logic                        oOverrun
);

  localparam int IDX_W = $clog2(NUM_PE);

  state_t state, stateNext;

  logic signed [ACC_W-1:0] snap [NUM_PE];
  logic [SHIFT_W-1:0]      shiftR;
  logic                    reluR;

  logic                    transfer;
  logic                    lastXfer;
  logic                    accept;
  logic [IDX_W-1:0]        nextIdx;
  logic signed [ACC_W-1:0] rqA;
  logic [SHIFT_W-1:0]      rqS;
  logic                    rqR;
  logic signed [OUT_W-1:0] rqQ;

  // A capture is only taken when the output side is free or is handing off
  // its last element this cycle; element 0 then comes straight from iAcc
  // because the snapshot is not loaded until the same edge.
  always_comb begin
    transfer = oValid && iReady;
    lastXfer = transfer && oLast;
    accept   = iCapture && (state == IDLE || lastXfer);
    nextIdx  = oIndex + IDX_W'(1);
    if (accept) begin
      rqA = iAcc[0 +: ACC_W];
      rqS = iShift;
      rqR = iRelu;
    end else begin
      rqA = snap[nextIdx];
      rqS = shiftR;
      rqR = reluR;
    end
  end

  requant_sat #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) uRequant (
    .a   (rqA),
    .s   (rqS),
    .relu(rqR),
    .q   (rqQ)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = DRAIN;
      DRAIN:   if (lastXfer && !iCapture) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst)
      state <= IDLE;
    else
      state <= stateNext;
  end

  assign oBusy = (state == DRAIN);

  always_ff @(posedge iClk) begin
    if (accept) begin
      for (int k = 0; k < NUM_PE; k++)
        snap[k] <= iAcc[k*ACC_W +: ACC_W];
      shiftR <= iShift;
      reluR  <= iRelu;
    end
  end

  // Output registers advance on a capture or a transfer and otherwise hold.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid   <= 1'b0;
      oData    <= '0;
      oIndex   <= '0;
      oLast    <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oOverrun <= iCapture && (state == DRAIN) && !lastXfer;
      if (accept) begin
        oValid <= 1'b1;
        oData  <= rqQ;
        oIndex <= '0;
        oLast  <= 1'b0;
      end else if (transfer) begin
        if (oLast) begin
          oValid <= 1'b0;
          oData  <= '0;
          oIndex <= '0;
          oLast  <= 1'b0;
        end else begin
          oData  <= rqQ;
          oIndex <= nextIdx;
          oLast  <= (nextIdx == IDX_W'(NUM_PE - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: directed vector table, hand-written
// stall/overrun/reset sequences and a randomised run against a queue model.
module tb_acc_drain;

  localparam int NUM_PE  = 4;
  localparam int ACC_W   = 20;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;

  logic                      iClk = 1'b0;
  logic                      iRst;
  logic [NUM_PE*ACC_W-1:0]   iAcc;
  logic                      iCapture;
  logic [SHIFT_W-1:0]        iShift;
  logic                      iRelu;
  logic                      oValid;
  logic                      iReady;
  logic [OUT_W-1:0]          oData;
  logic [1:0]                oIndex;
  logic                      oLast;
  logic                      oBusy;
  logic                      oOverrun;

  acc_drain #(
    .NUM_PE (NUM_PE),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iAcc    (iAcc),
    .iCapture(iCapture),
    .iShift  (iShift),
    .iRelu   (iRelu),
    .oValid  (oValid),
    .iReady  (iReady),
    .oData   (oData),
    .oIndex  (oIndex),
    .oLast   (oLast),
    .oBusy   (oBusy),
    .oOverrun(oOverrun)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    int acc0;
    int shift;
    bit relu;
    int expData;
  } vec_t;

  typedef struct {
    int data;
    int idx;
  } elem_t;

  int    nTests = 0;
  int    nFail  = 0;
  vec_t  vecs [14];
  elem_t q [$];
  int    curAcc [NUM_PE];
  int    seen [$];
  int    prevData, prevIdx;
  bit    prevStall;
  int    cyc, tilesDone, tilesAcc, xferCount;
  bit    xfer, canAcc, accOk, expOv;

  // Rounding is exact integer arithmetic: round-half-up of a / 2^s, then
  // ReLU and clamping; shifts past the accumulator width keep only the sign.
  function automatic int refQuant(input longint a, input int s, input bit relu);
    longint r;
    if (s == 0)
      r = a;
    else if (s <= ACC_W)
      r = (a + (longint'(1) << (s - 1))) >>> s;
    else
      r = (a < 0) ? -1 : 0;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic applyStimulus(input int a0, input int a1, input int a2, input int a3,
                               input int shift, input bit relu, input bit cap);
    iAcc     = {20'(a3), 20'(a2), 20'(a1), 20'(a0)};
    iShift   = SHIFT_W'(shift);
    iRelu    = relu;
    iCapture = cap;
  endtask

  task automatic expectOut(input string name, input bit v, input int d, input int idx,
                           input bit last);
    checkOutput({name, ".valid"}, int'(oValid), int'(v));
    checkOutput({name, ".data"},  int'($signed(oData)), d);
    checkOutput({name, ".index"}, int'(oIndex), idx);
    checkOutput({name, ".last"},  int'(oLast), int'(last));
  endtask

  function automatic int randAcc();
    int a;
    if ($urandom_range(0, 1) == 0) begin
      a = int'($urandom_range(0, 20'hFFFFF));
      if (a >= (1 << 19)) a -= (1 << 20);
    end else begin
      a = int'($urandom_range(0, 4000)) - 2000;
    end
    return a;
  endfunction

  initial begin
    vecs[0]  = '{1000,     3, 1'b0, 125};
    vecs[1]  = '{1004,     3, 1'b0, 126};
    vecs[2]  = '{-300,     3, 1'b0, -37};
    vecs[3]  = '{'h7FFFF,  3, 1'b0, 127};
    vecs[4]  = '{-300,     0, 1'b0, -128};
    vecs[5]  = '{-300,     0, 1'b1, 0};
    vecs[6]  = '{-524288, 31, 1'b0, -1};
    vecs[7]  = '{-524288, 20, 1'b0, 0};
    vecs[8]  = '{12,       2, 1'b0, 3};
    vecs[9]  = '{-6,       2, 1'b0, -1};
    vecs[10] = '{-7,       2, 1'b0, -2};
    vecs[11] = '{1023,     3, 1'b1, 127};
    vecs[12] = '{-5,       1, 1'b1, 0};
    vecs[13] = '{5,        1, 1'b0, 3};

    iRst = 1'b1;
    iReady = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    iRst = 1'b0;
    expectOut("reset", 1'b0, 0, 0, 1'b0);
    checkOutput("reset.busy", int'(oBusy), 0);
    checkOutput("reset.overrun", int'(oOverrun), 0);

    // Element 0 of each vector, held with iReady low, then drained.
    for (int i = 0; i < 14; i++) begin
      iReady = 1'b0;
      applyStimulus(vecs[i].acc0, 1, 2, 3, vecs[i].shift, vecs[i].relu, 1'b1);
      tick();
      iCapture = 1'b0;
      expectOut($sformatf("vec%0d", i), 1'b1, vecs[i].expData, 0, 1'b0);
      checkOutput($sformatf("vec%0d.busy", i), int'(oBusy), 1);
      iReady = 1'b1;
      for (int k = 0; k < NUM_PE; k++) tick();
      checkOutput($sformatf("vec%0d.idle", i), int'(oValid), 0);
    end

    // Full tile at full throughput.
    iReady = 1'b1;
    applyStimulus(1000, 1004, -300, 'h7FFFF, 3, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    expectOut("tile1.e0", 1'b1, 125, 0, 1'b0);
    tick();
    expectOut("tile1.e1", 1'b1, 126, 1, 1'b0);
    tick();
    expectOut("tile1.e2", 1'b1, -37, 2, 1'b0);
    tick();
    expectOut("tile1.e3", 1'b1, 127, 3, 1'b1);
    tick();
    expectOut("tile1.done", 1'b0, 0, 0, 1'b0);
    checkOutput("tile1.busy", int'(oBusy), 0);

    // Alternating iReady: stalled values hold, nothing skipped or duplicated.
    iReady = 1'b0;
    applyStimulus(10, 20, 30, 40, 0, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    seen.delete();
    prevStall = 1'b0;
    for (int c = 0; c < 20 && oValid; c++) begin
      iReady = c[0];
      if (oValid && iReady) seen.push_back(int'($signed(oData)));
      prevStall = oValid && !iReady;
      prevData  = int'($signed(oData));
      prevIdx   = int'(oIndex);
      tick();
      if (prevStall) begin
        checkOutput("stall.hold.data", int'($signed(oData)), prevData);
        checkOutput("stall.hold.index", int'(oIndex), prevIdx);
      end
    end
    checkOutput("stall.count", seen.size(), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("stall.seq%0d", k), (k < seen.size()) ? seen[k] : -999,
                  10 * (k + 1));

    // Overrun mid-drain, then back-to-back capture on the last transfer.
    iReady = 1'b1;
    applyStimulus(1, 2, 3, 4, 0, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    tick();
    expectOut("ovr.at1", 1'b1, 2, 1, 1'b0);
    iReady = 1'b0;
    applyStimulus(90, 91, 92, 93, 0, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    checkOutput("ovr.pulse", int'(oOverrun), 1);
    expectOut("ovr.held", 1'b1, 2, 1, 1'b0);
    iReady = 1'b1;
    tick();
    checkOutput("ovr.pulseEnd", int'(oOverrun), 0);
    expectOut("ovr.e2", 1'b1, 3, 2, 1'b0);
    tick();
    expectOut("ovr.e3", 1'b1, 4, 3, 1'b1);
    applyStimulus(5, 6, 7, 8, 0, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    expectOut("b2b.e0", 1'b1, 5, 0, 1'b0);
    checkOutput("b2b.overrun", int'(oOverrun), 0);
    tick();
    expectOut("b2b.e1", 1'b1, 6, 1, 1'b0);
    tick();
    tick();
    expectOut("b2b.e3", 1'b1, 8, 3, 1'b1);
    tick();
    expectOut("b2b.done", 1'b0, 0, 0, 1'b0);

    // Reset mid-drain discards the tile; the next capture drains normally.
    applyStimulus(50, 60, 70, 80, 0, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    tick();
    tick();
    expectOut("rst.at2", 1'b1, 70, 2, 1'b0);
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    expectOut("rst.cleared", 1'b0, 0, 0, 1'b0);
    checkOutput("rst.busy", int'(oBusy), 0);
    applyStimulus(-50, -60, -70, -80, 1, 1'b0, 1'b1);
    tick();
    iCapture = 1'b0;
    expectOut("rst.new.e0", 1'b1, -25, 0, 1'b0);
    tick();
    expectOut("rst.new.e1", 1'b1, -30, 1, 1'b0);
    tick();
    tick();
    expectOut("rst.new.e3", 1'b1, -40, 3, 1'b1);
    tick();
    checkOutput("rst.new.done", int'(oValid), 0);

    // Randomised tiles against the queue model.
    q.delete();
    cyc = 0;
    tilesDone = 0;
    tilesAcc = 0;
    xferCount = 0;
    while (tilesDone < 10000 && cyc < 90000) begin
      iReady = ($urandom_range(0, 7) != 0);
      xfer   = (q.size() > 0) && iReady;
      canAcc = (q.size() == 0) || (q.size() == 1 && xfer);
      for (int k = 0; k < NUM_PE; k++) curAcc[k] = randAcc();
      applyStimulus(curAcc[0], curAcc[1], curAcc[2], curAcc[3],
                    int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    canAcc ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0));
      accOk = iCapture && canAcc;
      expOv = iCapture && !canAcc;
      tick();
      cyc++;
      if (xfer) begin
        xferCount++;
        if (q[0].idx == NUM_PE - 1) tilesDone++;
        void'(q.pop_front());
      end
      if (accOk) begin
        tilesAcc++;
        for (int k = 0; k < NUM_PE; k++)
          q.push_back('{refQuant(longint'(curAcc[k]), int'(iShift), iRelu), k});
      end
      checkOutput("rand.valid", int'(oValid), int'(q.size() > 0));
      checkOutput("rand.overrun", int'(oOverrun), int'(expOv));
      checkOutput("rand.busy", int'(oBusy), int'(q.size() > 0));
      if (q.size() > 0) begin
        checkOutput("rand.data", int'($signed(oData)), q[0].data);
        checkOutput("rand.index", int'(oIndex), q[0].idx);
        checkOutput("rand.last", int'(oLast), int'(q[0].idx == NUM_PE - 1));
      end
    end
    checkOutput("rand.tileBudget", int'(tilesDone >= 10000), 1);
    checkOutput("rand.xferCount", xferCount, NUM_PE * tilesDone);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
